// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, requester ids and store byte-mask constants
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IFU/LSU request-response channels and the shared memory port
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MASK_WIDTH = 8
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_rsp_valid;
    logic [DATA_WIDTH-1:0] ifu_rdata;
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wen;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [MASK_WIDTH-1:0] lsu_wmask;
    logic                  lsu_rsp_valid;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport master (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata, lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
    modport slave (
        output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/arb_grant.sv
// arb_grant: two-way grant, fixed LSU priority or round-robin on contention (ARB_ROUND_ROBIN_EN)
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant
);
`ifdef ARB_ROUND_ROBIN_EN
    assign grant = (ifu_valid && lsu_valid) ? ~last_grant : (lsu_valid ? REQ_LSU : REQ_IFU);
`else
    logic unused_inputs;
    assign unused_inputs = ifu_valid ^ last_grant;
    assign grant = lsu_valid ? REQ_LSU : REQ_IFU;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU; ARB_ROUND_ROBIN_EN selects round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus,
    output logic                busy
);
    state_t state;
    state_t state_nx;
    logic   last_grant;
    logic   pick;
    logic   accept;

    arb_grant u_arb (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign accept = bus.ifu_req_ready || bus.lsu_req_ready;
    assign busy = state != IDLE;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state, request acceptance and response strobes
    always_comb begin
        state_nx = state;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.ifu_req_ready = bus.ifu_req_valid && pick == REQ_IFU;
                bus.lsu_req_ready = bus.lsu_req_valid && pick == REQ_LSU;
                state_nx = (bus.ifu_req_valid || bus.lsu_req_valid) ? REQ : IDLE;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                state_nx = bus.mem_req_ready ? WAIT : REQ;
            end
            WAIT: state_nx = bus.mem_rsp_valid ? RESP : WAIT;
            RESP: begin
                bus.ifu_rsp_valid = last_grant == REQ_IFU;
                bus.lsu_rsp_valid = last_grant == REQ_LSU;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // latch request fields and grant on handshake; route response data to the granted requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ_IFU;
            bus.mem_addr <= '0;
            bus.mem_wen <= 1'b0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
            bus.ifu_rdata <= '0;
            bus.lsu_rdata <= '0;
        end else begin
            if (accept) begin
                last_grant <= pick;
                bus.mem_addr <= pick == REQ_LSU ? bus.lsu_addr : bus.ifu_addr;
                bus.mem_wen <= pick == REQ_LSU && bus.lsu_wen;
                bus.mem_wdata <= pick == REQ_LSU ? bus.lsu_wdata : '0;
                bus.mem_wmask <= pick == REQ_LSU ? bus.lsu_wmask : '0;
            end
            if (state == WAIT && bus.mem_rsp_valid) begin
                if (last_grant == REQ_LSU)
                    bus.lsu_rdata <= bus.mem_rdata;
                else
                    bus.ifu_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rsp_cyc = 0;
    exp_t sb[$];
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        seen_wen;
    logic [7:0]  seen_wmask;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // response monitor: every rsp pulse must match the oldest expected response
    always @(negedge clk) begin
        if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
            exp_t e;
            exp_t got;
            pulses++;
            rsp_cyc = cyc;
            got.id = bus.lsu_rsp_valid;
            got.data = got.id ? bus.lsu_rdata : bus.ifu_rdata;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: ifu_rsp=%b lsu_rsp=%b, required no pulse", bus.ifu_rsp_valid, bus.lsu_rsp_valid);
            end else begin
                e = sb.pop_front();
                if ((bus.ifu_rsp_valid && bus.lsu_rsp_valid) || got !== e) begin
                    errors++;
                    $display("FAIL rsp: id=%0d data=%h (both=%b), required id=%0d data=%h",
                             got.id, got.data, bus.ifu_rsp_valid && bus.lsu_rsp_valid, e.id, e.data);
                end
            end
        end
    end

    task automatic wait_grant(output logic id, output bit ok);
        int n = 0;
        #1;
        while (!bus.ifu_req_ready && !bus.lsu_req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = bus.ifu_req_ready || bus.lsu_req_ready;
        id = bus.lsu_req_ready ? REQ_LSU : REQ_IFU;
    endtask

    task automatic issue(input logic id, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [7:0] wmask);
        logic g;
        bit ok;
        if (id == REQ_LSU) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_addr = addr;
            bus.lsu_wen = wen;
            bus.lsu_wdata = wdata;
            bus.lsu_wmask = wmask;
        end else begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_addr = addr;
        end
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== id) begin
            errors++;
            $display("FAIL grant: granted=%b id=%0d, required id=%0d", ok, g, id);
        end
        hs_cyc = cyc + 1;
        @(negedge clk);
        if (id == REQ_LSU)
            bus.lsu_req_valid = 1'b0;
        else
            bus.ifu_req_valid = 1'b0;
    endtask

    task automatic serve_mem(input int rdy_dly, input int rsp_dly, input logic [31:0] data);
        int n = 0;
        while (!bus.mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.mem_req_valid) begin
            errors++;
            $display("FAIL mem_req_timeout: mem_req_valid=0 after %0d cycles, required 1", n);
            return;
        end
        seen_addr = bus.mem_addr;
        seen_wen = bus.mem_wen;
        seen_wdata = bus.mem_wdata;
        seen_wmask = bus.mem_wmask;
        repeat (rdy_dly) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (rsp_dly) @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b, required 000000",
                     {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, busy});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wen !== 1'b0 || bus.mem_wdata !== 32'h0 || bus.mem_wmask !== 8'h0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h wen=%b wdata=%h wmask=%h, required all 0",
                     bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
        end
        checks++;
        if (bus.ifu_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: ifu=%h lsu=%h, required 0", bus.ifu_rdata, bus.lsu_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic g;
        bit ok;
        logic exp2;
`ifdef ARB_ROUND_ROBIN_EN
        exp2 = REQ_IFU;
`else
        exp2 = REQ_LSU;
`endif
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr = 32'h8000_0100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr = 32'h8000_2000;
        bus.lsu_wen = 1'b0;
        bus.lsu_wmask = MASK_W;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== REQ_LSU) begin
            errors++;
            $display("FAIL contention1: granted=%b id=%0d, required id=%0d", ok, g, REQ_LSU);
        end
        sb.push_back('{REQ_LSU, 32'h1111_1111});
        @(negedge clk);
        bus.lsu_addr = 32'h8000_2004;
        serve_mem(0, 0, 32'h1111_1111);
        checks++;
        if (seen_addr !== 32'h8000_2000) begin
            errors++;
            $display("FAIL contention1_addr: %h, required 80002000", seen_addr);
        end
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== exp2) begin
            errors++;
            $display("FAIL contention2: granted=%b id=%0d, required id=%0d", ok, g, exp2);
        end
        sb.push_back('{exp2, 32'h2222_2222});
        @(negedge clk);
        if (exp2 == REQ_LSU)
            bus.lsu_req_valid = 1'b0;
        else
            bus.ifu_req_valid = 1'b0;
        serve_mem(0, 0, 32'h2222_2222);
        checks++;
        if (seen_addr !== (exp2 == REQ_LSU ? 32'h8000_2004 : 32'h8000_0100)) begin
            errors++;
            $display("FAIL contention2_addr: %h, required winner address", seen_addr);
        end
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== ~exp2) begin
            errors++;
            $display("FAIL contention3: granted=%b id=%0d, required id=%0d", ok, g, ~exp2);
        end
        sb.push_back('{~exp2, 32'h3333_3333});
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        serve_mem(0, 0, 32'h3333_3333);
        checks++;
        if (seen_addr !== (exp2 == REQ_LSU ? 32'h8000_0100 : 32'h8000_2004)) begin
            errors++;
            $display("FAIL contention3_addr: %h, required remaining address", seen_addr);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL contention_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_fetch();
        int p0 = pulses;
        sb.push_back('{REQ_IFU, 32'h0000_0413});
        fork
            issue(REQ_IFU, 32'h8000_0000, 1'b0, 32'h0, 8'h0);
            serve_mem(0, 0, 32'h0000_0413);
        join
        drain();
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL fetch_pulses: %0d, required 1", pulses - p0);
        end
        checks++;
        if (rsp_cyc != hs_cyc + 2) begin
            errors++;
            $display("FAIL fetch_latency: rsp seen after edge %0d, required %0d", rsp_cyc, hs_cyc + 2);
        end
        checks++;
        if (bus.ifu_rdata !== 32'h0000_0413) begin
            errors++;
            $display("FAIL fetch_rdata_hold: %h, required 00000413", bus.ifu_rdata);
        end
        checks++;
        if (seen_addr !== 32'h8000_0000 || seen_wen !== 1'b0 || seen_wmask !== 8'h0) begin
            errors++;
            $display("FAIL fetch_fields: addr=%h wen=%b wmask=%h, required 80000000 0 00", seen_addr, seen_wen, seen_wmask);
        end
    endtask

    task automatic test_store();
        int p0 = pulses;
        sb.push_back('{REQ_LSU, 32'h0});
        fork
            issue(REQ_LSU, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, MASK_W);
            serve_mem(0, 2, 32'h0);
        join
        drain();
        checks++;
        if (seen_addr !== 32'h8000_1000 || seen_wen !== 1'b1 || seen_wdata !== 32'hDEAD_BEEF || seen_wmask !== MASK_W) begin
            errors++;
            $display("FAIL store_fields: addr=%h wen=%b wdata=%h wmask=%h, required 80001000 1 deadbeef 0f",
                     seen_addr, seen_wen, seen_wdata, seen_wmask);
        end
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL store_pulses: %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        int h1 = 0;
        int p0 = pulses;
        sb.push_back('{REQ_IFU, 32'h0000_0093});
        sb.push_back('{REQ_LSU, 32'h1234_5678});
        fork
            begin
                issue(REQ_IFU, 32'h8000_0004, 1'b0, 32'h0, 8'h0);
                h1 = hs_cyc;
                issue(REQ_LSU, 32'h8000_1008, 1'b0, 32'h0, MASK_W);
            end
            begin
                serve_mem(0, 0, 32'h0000_0093);
                serve_mem(0, 0, 32'h1234_5678);
            end
        join
        drain();
        checks++;
        if (hs_cyc - h1 != 4) begin
            errors++;
            $display("FAIL b2b_accept_gap: %0d cycles, required 4", hs_cyc - h1);
        end
        checks++;
        if (pulses - p0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: %0d, required 2", pulses - p0);
        end
        checks++;
        if (seen_addr !== 32'h8000_1008 || seen_wen !== 1'b0 || seen_wmask !== MASK_W) begin
            errors++;
            $display("FAIL b2b_fields: addr=%h wen=%b wmask=%h, required 80001008 0 0f", seen_addr, seen_wen, seen_wmask);
        end
        checks++;
        if (bus.ifu_rdata !== 32'h0000_0093 || bus.lsu_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_rdata: ifu=%h lsu=%h, required 00000093 12345678", bus.ifu_rdata, bus.lsu_rdata);
        end
    endtask

    task automatic test_backpressure();
        logic g;
        bit ok;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr = 32'h8000_0200;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== REQ_IFU) begin
            errors++;
            $display("FAIL bp_grant_ifu: granted=%b id=%0d, required id=0", ok, g);
        end
        sb.push_back('{REQ_IFU, 32'h0000_0013});
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr = 32'h8000_3000;
        bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 32'hCAFE_F00D;
        bus.lsu_wmask = MASK_H;
        fork
            serve_mem(3, 0, 32'h0000_0013);
            begin
                for (int i = 0; i < 4; i++) begin
                    #1;
                    checks++;
                    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0200 || bus.mem_wen !== 1'b0 ||
                        bus.mem_wmask !== 8'h0 || bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_stall%0d: valid=%b addr=%h wen=%b wmask=%h rdy=%b%b, required 1 80000200 0 00 00",
                                 i, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask, bus.ifu_req_ready, bus.lsu_req_ready);
                    end
                    @(negedge clk);
                end
                #1;
                checks++;
                if (bus.mem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_release: mem_req_valid=%b, required 0", bus.mem_req_valid);
                end
            end
        join
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== REQ_LSU) begin
            errors++;
            $display("FAIL bp_grant_lsu: granted=%b id=%0d, required id=1", ok, g);
        end
        sb.push_back('{REQ_LSU, 32'h0});
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        serve_mem(0, 1, 32'h0);
        checks++;
        if (seen_addr !== 32'h8000_3000 || seen_wen !== 1'b1 || seen_wdata !== 32'hCAFE_F00D || seen_wmask !== MASK_H) begin
            errors++;
            $display("FAIL bp_store_fields: addr=%h wen=%b wdata=%h wmask=%h, required 80003000 1 cafef00d 03",
                     seen_addr, seen_wen, seen_wdata, seen_wmask);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_reset_in_wait();
        logic g;
        bit ok;
        int p0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr = 32'h8000_0300;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== REQ_IFU) begin
            errors++;
            $display("FAIL rw_grant: granted=%b id=%0d, required id=0", ok, g);
        end
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_in_wait: busy=%b mem_req_valid=%b, required 1 0", busy, bus.mem_req_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_after_reset: busy=%b mem_req_valid=%b, required 0 0", busy, bus.mem_req_valid);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = 32'hBAD0_0001;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pulses != p0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rw_stale_rsp: pulses=%0d busy=%b, required 0 0", pulses - p0, busy);
        end
        checks++;
        if (bus.ifu_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rw_rdata: ifu=%h lsu=%h, required 0 0", bus.ifu_rdata, bus.lsu_rdata);
        end
    endtask

    task automatic test_stray_rsp();
        int p0 = pulses;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pulses != p0 || busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ctrl: pulses=%0d busy=%b mem_req_valid=%b, required 0 0 0", pulses - p0, busy, bus.mem_req_valid);
        end
        checks++;
        if (bus.ifu_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stray_rdata: ifu=%h lsu=%h, required 0 0", bus.ifu_rdata, bus.lsu_rdata);
        end
    endtask

    initial begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr = 32'h0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr = 32'h0;
        bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 32'h0;
        bus.lsu_wmask = 8'h0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_contention();
        test_fetch();
        test_store();
        test_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        test_stray_rsp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
